// File: rtl/if_id_fetch_pkg.sv
// Shared constants, FSM encoding and address helper for the fetch stage
// and its IF/ID register.
package if_id_fetch_pkg;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_WAIT_ID = 2'd1,
        ST_DROP    = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {ir,pc} holding buffer that parks a fetched word while decode
// is stalled.
module if_skid_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_unload,
    input  logic        i_clear,
    input  logic [31:0] i_ir,
    input  logic [31:0] i_pc,
    output logic [31:0] o_ir,
    output logic [31:0] o_pc,
    output logic        o_full
);

    logic        r_full;
    logic [31:0] r_ir;
    logic [31:0] r_pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_full <= 1'b0;
        end else if (i_clear || i_unload) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_full <= 1'b1;
        end
    end

    // NOTE: payload needs no reset; it is only observed while r_full is set.
    always_ff @(posedge clk) begin
        if (i_load && !i_clear) begin
            r_ir <= i_ir;
            r_pc <= i_pc;
        end
    end

    assign o_ir   = r_ir;
    assign o_pc   = r_pc;
    assign o_full = r_full;

endmodule

// File: rtl/if_id_fetch.sv
// Instruction fetch stage with IF/ID register: owns the PC, keeps at most one
// memory request outstanding, buffers one word on stall, flushes on redirect.
module if_id_fetch
    import if_id_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_ir,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
);

    fetch_state_t r_state, w_state_nxt;
    logic         r_run;
    logic [31:0]  r_pc, w_pc_nxt;
    logic [31:0]  r_drop_addr, w_drop_addr_nxt;
    logic         r_id_valid, w_id_valid_nxt;
    logic [31:0]  r_id_ir, w_id_ir_nxt;
    logic [31:0]  r_id_pc, w_id_pc_nxt;
    logic [31:0]  r_id_pc_plus4, w_id_pc_plus4_nxt;

    logic         w_skid_load, w_skid_unload, w_skid_clear, w_skid_full;
    logic [31:0]  w_skid_ir, w_skid_pc;
    logic         w_complete;

    if_skid_buf u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_skid_load),
        .i_unload (w_skid_unload),
        .i_clear  (w_skid_clear),
        .i_ir     (imem_rdata),
        .i_pc     (r_pc),
        .o_ir     (w_skid_ir),
        .o_pc     (w_skid_pc),
        .o_full   (w_skid_full)
    );

    // r_run keeps the request low for the first cycle after reset release.
    assign imem_req   = r_run && (((r_state == ST_FETCH) && !w_skid_full) ||
                                  (r_state == ST_DROP));
    assign imem_addr  = (r_state == ST_DROP) ? r_drop_addr : r_pc;
    assign w_complete = imem_req && imem_ready;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_drop_addr_nxt   = r_drop_addr;
        w_id_valid_nxt    = r_id_valid;
        w_id_ir_nxt       = r_id_ir;
        w_id_pc_nxt       = r_id_pc;
        w_id_pc_plus4_nxt = r_id_pc_plus4;
        w_skid_load       = 1'b0;
        w_skid_unload     = 1'b0;
        w_skid_clear      = 1'b0;

        if (redirect) begin
            w_id_valid_nxt = 1'b0;
            w_id_ir_nxt    = NOP_INSTR;
            w_skid_clear   = 1'b1;
            w_pc_nxt       = word_align(redirect_pc);
            if (imem_req && !imem_ready) begin
                w_state_nxt     = ST_DROP;
                w_drop_addr_nxt = imem_addr;
            end else begin
                w_state_nxt = ST_FETCH;
            end
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (w_complete) begin
                        w_pc_nxt = r_pc + 32'd4;
                        if (stall) begin
                            w_skid_load = 1'b1;
                            w_state_nxt = ST_WAIT_ID;
                        end else begin
                            w_id_valid_nxt    = 1'b1;
                            w_id_ir_nxt       = imem_rdata;
                            w_id_pc_nxt       = r_pc;
                            w_id_pc_plus4_nxt = r_pc + 32'd4;
                        end
                    end else if (!stall) begin
                        w_id_valid_nxt = 1'b0;
                        w_id_ir_nxt    = NOP_INSTR;
                    end
                end
                ST_WAIT_ID: begin
                    if (!stall) begin
                        w_id_valid_nxt    = 1'b1;
                        w_id_ir_nxt       = w_skid_ir;
                        w_id_pc_nxt       = w_skid_pc;
                        w_id_pc_plus4_nxt = w_skid_pc + 32'd4;
                        w_skid_unload     = 1'b1;
                        w_state_nxt       = ST_FETCH;
                    end
                end
                ST_DROP: begin
                    // The stale word is discarded; the IF/ID register already holds a bubble.
                    if (w_complete) begin
                        w_state_nxt = ST_FETCH;
                    end
                end
                default: w_state_nxt = ST_FETCH;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_FETCH;
            r_run         <= 1'b0;
            r_pc          <= RESET_PC;
            r_drop_addr   <= 32'd0;
            r_id_valid    <= 1'b0;
            r_id_ir       <= NOP_INSTR;
            r_id_pc       <= 32'd0;
            r_id_pc_plus4 <= 32'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_run         <= 1'b1;
            r_pc          <= w_pc_nxt;
            r_drop_addr   <= w_drop_addr_nxt;
            r_id_valid    <= w_id_valid_nxt;
            r_id_ir       <= w_id_ir_nxt;
            r_id_pc       <= w_id_pc_nxt;
            r_id_pc_plus4 <= w_id_pc_plus4_nxt;
        end
    end

    assign id_valid    = r_id_valid;
    assign id_ir       = r_id_ir;
    assign id_pc       = r_id_pc;
    assign id_pc_plus4 = r_id_pc_plus4;

endmodule

// File: tb/tb_if_id_fetch.sv
// Directed bench for if_id_fetch: a latency-programmable memory on the main
// instance and a zero-latency memory on a second instance with a high RESET_PC.
module tb_if_id_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        imem_req, imem_ready;
    logic [31:0] imem_addr, imem_rdata;
    logic        id_valid;
    logic [31:0] id_ir, id_pc, id_pc_plus4;

    logic        w2_req;
    logic [31:0] w2_addr, w2_rdata;
    logic        w2_valid;
    logic [31:0] w2_ir, w2_pc, w2_pc_plus4;

    int n_checks = 0;
    int n_errors = 0;
    int wait_cycles = 0;
    int wait_cnt = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~a;
    endfunction

    // Memory: ready once the request has been held for wait_cycles extra cycles.
    assign imem_ready = imem_req && (wait_cnt >= wait_cycles);
    assign imem_rdata = mem_word(imem_addr);
    always @(posedge clk) begin
        if (!imem_req || imem_ready) wait_cnt <= 0;
        else                         wait_cnt <= wait_cnt + 1;
    end

    assign w2_rdata = mem_word(w2_addr);

    if_id_fetch u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_ir       (id_ir),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4)
    );

    if_id_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (w2_req),
        .imem_addr   (w2_addr),
        .imem_ready  (1'b1),
        .imem_rdata  (w2_rdata),
        .stall       (1'b0),
        .redirect    (1'b0),
        .redirect_pc (32'd0),
        .id_valid    (w2_valid),
        .id_ir       (w2_ir),
        .id_pc       (w2_pc),
        .id_pc_plus4 (w2_pc_plus4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_id(input string tag, input logic v, input logic [31:0] pc);
        check({tag, ".valid"}, {31'd0, id_valid}, {31'd0, v});
        check({tag, ".ir"}, id_ir, v ? mem_word(pc) : NOP);
        if (v) begin
            check({tag, ".pc"}, id_pc, pc);
            check({tag, ".pc4"}, id_pc_plus4, pc + 32'd4);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        #2;
        tick(); tick();
        check("rst.valid", {31'd0, id_valid}, 32'd0);
        check("rst.ir", id_ir, NOP);
        check("rst.pc", id_pc, 32'd0);
        check("rst.pc4", id_pc_plus4, 32'd0);
        check("rst.req", {31'd0, imem_req}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel.req_low", {31'd0, imem_req}, 32'd0);
        tick();
        check("rel.req", {31'd0, imem_req}, 32'd1);
        check("rel.addr", imem_addr, 32'd0);
        check("rel.valid", {31'd0, id_valid}, 32'd0);

        // Zero latency: one instruction per cycle; wrap instance crosses 2^32.
        for (int i = 0; i < 4; i++) begin
            a = 32'hFFFF_FFF8 + 32'(4 * i);
            check($sformatf("wrap.addr%0d", i), w2_addr, a);
            check($sformatf("zl.addr%0d", i), imem_addr, 32'(4 * i));
            tick();
            check_id($sformatf("zl%0d", i), 1'b1, 32'(4 * i));
            check($sformatf("wrap.pc%0d", i), w2_pc, a);
            check($sformatf("wrap.pc4_%0d", i), w2_pc_plus4, a + 32'd4);
        end

        // Three-cycle latency: address held, bubbles then a valid word.
        wait_cycles = 2;
        for (int j = 0; j < 2; j++) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("lat.addr%0d_%0d", j, k), imem_addr, 32'(16 + 4 * j));
                tick();
                check_id($sformatf("lat%0d_%0d", j, k), k == 2, 32'(16 + 4 * j));
            end
        end

        // Stall for 4 cycles across a completion: word parked in skid.
        wait_cycles = 0;
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_id($sformatf("stall%0d", k), 1'b1, 32'd20);
            check($sformatf("stall.req%0d", k), {31'd0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        tick();
        check_id("unskid", 1'b1, 32'd24);
        check("unskid.req", {31'd0, imem_req}, 32'd1);
        check("unskid.addr", imem_addr, 32'd28);
        tick();
        check_id("after_skid", 1'b1, 32'd28);

        // Redirect with a request outstanding at latency 2.
        wait_cycles = 1;
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        redirect = 1'b0;
        check_id("redir", 1'b0, 32'd0);
        check("drop.req", {31'd0, imem_req}, 32'd1);
        check("drop.addr", imem_addr, 32'd32);
        tick();
        check_id("drop.done", 1'b0, 32'd0);
        check("redir.addr", imem_addr, 32'h100);
        tick();
        check_id("redir.wait", 1'b0, 32'd0);
        tick();
        check_id("redir.first", 1'b1, 32'h100);

        // Redirect together with stall and a completing word.
        wait_cycles = 0;
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        stall = 1'b0; redirect = 1'b0;
        check_id("rs", 1'b0, 32'd0);
        check("rs.req", {31'd0, imem_req}, 32'd1);
        check("rs.addr", imem_addr, 32'h200);
        tick();
        check_id("rs.first", 1'b1, 32'h200);

        // Redirect while the skid holds a word: the parked word must vanish.
        stall = 1'b1;
        tick();
        check("ws.req", {31'd0, imem_req}, 32'd0);
        redirect = 1'b1; redirect_pc = 32'h0000_0300;
        tick();
        stall = 1'b0; redirect = 1'b0;
        check_id("ws.flush", 1'b0, 32'd0);
        check("ws.req_after", {31'd0, imem_req}, 32'd1);
        check("ws.addr", imem_addr, 32'h300);
        tick();
        check_id("ws.first", 1'b1, 32'h300);

        // Reset mid-stream.
        rst_n = 1'b0;
        tick();
        check("mrst.valid", {31'd0, id_valid}, 32'd0);
        check("mrst.ir", id_ir, NOP);
        check("mrst.pc", id_pc, 32'd0);
        check("mrst.pc4", id_pc_plus4, 32'd0);
        check("mrst.req", {31'd0, imem_req}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("mrst.req_up", {31'd0, imem_req}, 32'd1);
        check("mrst.addr", imem_addr, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/if_id_fetch.md
Name: if_id_fetch

Overview:
Instruction fetch stage plus IF/ID pipeline register for the FEMTORV32 pipelined core. It owns the PC, issues one-outstanding-request fetches to instruction memory, and tolerates variable memory latency. It buffers one word when decode stalls and discards in-flight words on branch/jump redirect. Its id_ir output is the IR consumed by the decode stage (opcode decode, immediate generation, register read).

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; first fetch address.
NOP_INSTR, 32'h0000_0013 (addi x0,x0,0), word driven on id_ir whenever id_valid=0.

Ports:
clk  in  1  single core clock; all state updates on rising edge.
rst_n  in  1  reset, synchronous, active-low.
imem_req  out  1  fetch request; imem_addr held stable while high.
imem_addr  out  32  byte address of fetch; bits [1:0] always 0.
imem_ready  in  1  response valid; sampled at clk edge while imem_req=1; completes transaction; may assert in the same cycle as req.
imem_rdata  in  32  instruction word, valid when imem_ready=1.
stall  in  1  from hazard unit; hold IF/ID register contents.
redirect  in  1  flush request from branch/jump resolution.
redirect_pc  in  32  new fetch target; bits [1:0] ignored (forced 0).
id_valid  out  1  IF/ID register holds a real instruction.
id_ir  out  32  instruction to decode; NOP_INSTR when id_valid=0.
id_pc  out  32  address of id_ir.
id_pc_plus4  out  32  id_pc+4, registered, modulo 2^32.

Behaviour:
- Reset (rst_n=0 at edge): pc=RESET_PC, state=FETCH, skid empty, imem_req=0, id_valid=0, id_ir=NOP_INSTR, id_pc=0, id_pc_plus4=0. imem_req first rises the cycle after rst_n goes high. Reset mid-transaction abandons it; memory must tolerate dropped requests.
- imem_req = (state==FETCH && !skid_full) || state==DROP. imem_addr = pc in FETCH; latched old address in DROP.
- Completion is an edge with imem_req=1 and imem_ready=1. Best-case throughput is 1 instr/cycle.
- States:
  - FETCH: on completion with no redirect:
    - if !stall: id_* <= {1, rdata, pc, pc+4}.
    - if stall: the word goes to skid; next state WAIT_ID.
    - pc <= pc+4 in both cases.
    - No completion and !stall: id_valid<=0, id_ir<=NOP_INSTR (bubble).
  - WAIT_ID: req=0. When stall=0, skid -> id_*, skid cleared, next state FETCH. Fetching resumes the following cycle.
  - DROP: entered on redirect while req=1 and no completion that edge. Req stays high at the old address; data is discarded on completion; next state FETCH.
- Redirect has highest priority, above stall and completion. On the redirect edge:
  - id_valid<=0, id_ir<=NOP_INSTR.
  - skid cleared.
  - pc<=redirect_pc & ~3.
  - A word completing on the same edge is discarded; next state FETCH.
  - Otherwise, if a request is outstanding, next state DROP.
  - First fetch of the target is issued no earlier than the cycle after.
- A stall with an empty skid and no completion holds id_* unchanged; no bubble is inserted.
- pc and pc+4 wrap modulo 2^32 (32'hFFFF_FFFC -> 0); no exception.
- At most one outstanding request. The skid holds exactly one word, so no word is ever lost or duplicated.

Decomposition:
- defines.v gains:
  - NOP_INSTR constant.
  - Default RESET_PC.
  - FSM state encodings FETCH=2'd0, WAIT_ID=2'd1, DROP=2'd2.
- One natural sub-module: if_skid_buf, a one-entry {ir,pc} buffer with load/unload/clear and a full flag.
- FSM and PC remain in the top.

Test Plan:
- Reset, then zero-latency memory (ready tied 1), mem[0..3]=I0..I3 -> from cycle 2 id_ir=I0,I1,I2,I3 on consecutive cycles; id_pc=0,4,8,C; id_pc_plus4=4,8,C,10.
- Memory latency 3 cycles -> imem_addr stable for 3 cycles per fetch; id_valid toggles 0,0,1; id_ir=NOP_INSTR on bubble cycles.
- stall=1 for 4 cycles while a fetch completes -> id_* frozen, skid captures the word, imem_req=0. After release, the next two id_ir values are the skid word then the next fetch, with no gap and no duplicate.
- redirect=1, redirect_pc=32'h0000_0103, with a request outstanding at latency 2 -> id_valid=0 next cycle; the stale word is discarded; next imem_addr=32'h0000_0100; first valid id_pc=32'h100.
- redirect and stall asserted together, and redirect coincident with imem_ready -> flush wins, returned word dropped, skid empty, next address = redirect_pc.
- RESET_PC=32'hFFFF_FFF8, ready tied 1 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; rst_n low mid-stream -> outputs reach reset values at the next edge.
